operand_scoreboard: RTL and testbench



---
 rtl/operand_scoreboard_pkg.sv | 19 +
 rtl/scoreboard_bank.sv | 39 +++
 rtl/operand_scoreboard.sv | 97 +++++++++
 tb/tb_operand_scoreboard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_scoreboard_pkg.sv
// Shared definitions for the operand scoreboard.
//   NREG      - architectural register count (width of every one-hot select)
//   ZERO_REG  - hard-wired zero register, never tracked
//   ZMASK     - all registers except ZERO_REG
//   state_e   - stall FSM states
//   is_onehot - exactly-one-bit-set check used for protocol checking
package operand_scoreboard_pkg;

    localparam int NREG     = 32;
    localparam int ZERO_REG = 31;
    localparam logic [NREG-1:0] ZMASK = ~(NREG'(1) << ZERO_REG);

    typedef enum logic {ST_RUN, ST_STALL} state_e;

    function automatic logic is_onehot(input logic [NREG-1:0] x);
        return (x != '0) && ((x & (x - NREG'(1))) == '0);
    endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// Pending-write bank: one bit per register plus an up/down count of the
// outstanding writes (kept incrementally, no popcount).
//   clk, reset        - clock, synchronous active-high reset
//   set_en, set_sel   - mark a register as having a write in flight
//   clr_en, clr_sel   - retire a register's outstanding write
//   pending           - registered scoreboard vector
//   inflight          - number of outstanding tracked writes
module scoreboard_bank
    import operand_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              set_en,
    input  logic [NREG-1:0]                   set_sel,
    input  logic                              clr_en,
    input  logic [NREG-1:0]                   clr_sel,
    output logic [NREG-1:0]                   pending,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);

    localparam int IW = $clog2(MAX_INFLIGHT+1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            inflight <= '0;
        end else begin
            // Clear first, then set: a same-register retire+issue leaves the bit high.
            pending <= (pending & ~(clr_en ? clr_sel : '0)) | (set_en ? set_sel : '0);
            if (set_en && !clr_en)
                inflight <= inflight + IW'(1);
            else if (clr_en && !set_en)
                inflight <= inflight - IW'(1);
        end
    end

endmodule

// File: rtl/operand_scoreboard.sv
// Issue-stage hazard controller. Compares the decoded Rn/Rm/Rd one-hot
// selects against writes still in flight and holds issue until safe.
//   clk, reset             - clock, synchronous active-high reset
//   id_valid / id_ready    - decode handshake; id_ready is purely combinational
//   rn_sel, rm_sel, uses_rm- source selects (Rm only when uses_rm)
//   rd_sel, rd_we          - destination select and write enable
//   wb_valid, wb_sel       - writeback retiring a tracked write
//   pending, inflight      - scoreboard state
//   stall, stall_cycles    - stall indication and saturating stall count
//   err                    - sticky protocol-error flag
module operand_scoreboard
    import operand_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    output logic                              id_ready,
    input  logic [NREG-1:0]                   rn_sel,
    input  logic [NREG-1:0]                   rm_sel,
    input  logic                              uses_rm,
    input  logic [NREG-1:0]                   rd_sel,
    input  logic                              rd_we,
    input  logic                              wb_valid,
    input  logic [NREG-1:0]                   wb_sel,
    output logic [NREG-1:0]                   pending,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              stall,
    output logic [CNT_W-1:0]                  stall_cycles,
    output logic                              err
);

    localparam int IW = $clog2(MAX_INFLIGHT+1);

    logic            wb_ok, wb_err, id_err;
    logic            raw, waw, full, hazard, rd_tracked, set_en;
    logic [NREG-1:0] eff, src;
    state_e          state_q, state_d;

    always_comb begin
        // Only a legal retire releases dependents, so a malformed writeback
        // can never let a reader past a write that is still outstanding.
        wb_ok      = wb_valid && is_onehot(wb_sel) && ((wb_sel & pending & ZMASK) != '0);
        wb_err     = wb_valid && (!is_onehot(wb_sel) ||
                                  (((wb_sel & ZMASK) != '0) && ((wb_sel & pending) == '0)));
        id_err     = (id_valid && (!is_onehot(rn_sel) || !is_onehot(rd_sel))) ||
                     (uses_rm && !is_onehot(rm_sel));
        eff        = pending & ZMASK & ~(wb_ok ? wb_sel : '0);
        src        = rn_sel | (uses_rm ? rm_sel : '0);
        rd_tracked = (rd_sel & ZMASK) != '0;
        raw        = (src & eff) != '0;
        waw        = rd_we && ((rd_sel & eff) != '0);
        full       = rd_we && rd_tracked && (inflight == IW'(MAX_INFLIGHT)) && !wb_ok;
        hazard     = id_valid && (raw || waw || full);
        set_en     = id_valid && !hazard && !id_err && rd_we && rd_tracked;
    end

    assign id_ready = !hazard;
    assign stall    = hazard;

    scoreboard_bank #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_bank (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_sel  (rd_sel & ZMASK),
        .clr_en   (wb_ok),
        .clr_sel  (wb_sel),
        .pending  (pending),
        .inflight (inflight)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall)  state_d = ST_STALL;
            ST_STALL: if (!stall) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            stall_cycles <= '0;
            err          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_STALL && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (id_err || wb_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_scoreboard.sv
module tb_operand_scoreboard;
    localparam int NREG = 32;
    localparam int ZR   = 31;
    localparam int MAXI = 4;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, id_ready, uses_rm, rd_we, wb_valid, stall, err;
    logic [NREG-1:0] rn_sel, rm_sel, rd_sel, wb_sel, pending;
    logic [2:0]      inflight;
    logic [CW-1:0]   stall_cycles;

    operand_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .rn_sel(rn_sel), .rm_sel(rm_sel), .uses_rm(uses_rm), .rd_sel(rd_sel),
        .rd_we(rd_we), .wb_valid(wb_valid), .wb_sel(wb_sel), .pending(pending),
        .inflight(inflight), .stall(stall), .stall_cycles(stall_cycles), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: in-flight writes kept as a list of register numbers.
    int outq[$];
    bit m_err;
    int m_cnt;
    bit last_stall;
    bit e_hazard, e_retire, e_issue, e_err;
    int e_wb, e_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] oh(input int i);
        logic [NREG-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int idx_of(input logic [NREG-1:0] v);
        int n = 0;
        int p = -1;
        for (int i = 0; i < NREG; i++) if (v[i]) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    function automatic bit in_q(input int r);
        foreach (outq[k]) if (outq[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Register r still blocks a reader/writer this cycle.
    function automatic bit busy(input int r);
        return (r != ZR) && in_q(r) && !(e_retire && r == e_wb);
    endfunction

    function automatic bit any_busy(input logic [NREG-1:0] v);
        for (int i = 0; i < NREG; i++) if (v[i] && busy(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NREG-1:0] pvec();
        logic [NREG-1:0] v;
        v = '0;
        foreach (outq[k]) v[outq[k]] = 1'b1;
        return v;
    endfunction

    task automatic predict();
        bit raw, waw, full, rd_trk, id_e, wb_e;
        e_wb     = wb_valid ? idx_of(wb_sel) : -1;
        e_retire = (e_wb >= 0) && (e_wb != ZR) && in_q(e_wb);
        e_rd     = idx_of(rd_sel);
        rd_trk   = 1'b0;
        for (int i = 0; i < NREG; i++) if (rd_sel[i] && i != ZR) rd_trk = 1'b1;
        raw      = any_busy(rn_sel) || (uses_rm && any_busy(rm_sel));
        waw      = rd_we && any_busy(rd_sel);
        full     = rd_we && rd_trk && (outq.size() == MAXI) && !e_retire;
        e_hazard = id_valid && (raw || waw || full);
        id_e     = (id_valid && (idx_of(rn_sel) < 0 || e_rd < 0)) || (uses_rm && idx_of(rm_sel) < 0);
        wb_e     = wb_valid && (e_wb < 0 || (e_wb != ZR && !in_q(e_wb)));
        e_issue  = id_valid && !e_hazard && !id_e && rd_we && rd_trk;
        e_err    = id_e || wb_e;
    endtask

    task automatic commit();
        if (e_retire)
            for (int k = 0; k < outq.size(); k++)
                if (outq[k] == e_wb) begin outq.delete(k); break; end
        if (e_issue) outq.push_back(e_rd);
        if (e_err) m_err = 1'b1;
        if (last_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        last_stall = e_hazard;
    endtask

    task automatic check_regs();
        chk("pending", pending, pvec());
        chk("inflight", inflight, outq.size());
        chk("stall_cycles", stall_cycles, m_cnt);
        chk("err", err, m_err);
    endtask

    // One clock: combinational checks mid-cycle, registered checks after the edge.
    task automatic step();
        @(negedge clk);
        predict();
        chk("id_ready", id_ready, !e_hazard);
        chk("stall", stall, e_hazard);
        @(posedge clk); #1;
        commit();
        check_regs();
    endtask

    task automatic drive(input bit iv, input int rn, input bit urm, input int rm,
                         input bit we, input int rd, input bit wv, input int wb);
        id_valid = iv;  rn_sel = oh(rn); uses_rm = urm; rm_sel = oh(rm);
        rd_we    = we;  rd_sel = oh(rd); wb_valid = wv; wb_sel = oh(wb);
    endtask

    task automatic idle();
        drive(0, ZR, 0, ZR, 0, ZR, 0, ZR);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        outq.delete();
        m_err = 1'b0; m_cnt = 0; last_stall = 1'b0;
        check_regs();
    endtask

    function automatic int pick();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 7)) : ZR;
    endfunction

    initial begin
        reset = 1'b0;
        do_reset();
        chk("rst_pending", pending, 32'h0);
        chk("rst_cnt", stall_cycles, 0);
        step();

        // Simple issue X2 <- X1
        drive(1, 1, 0, 0, 1, 2, 0, 0); step();
        chk("t1_pending", pending, 32'h4);
        chk("t1_inflight", inflight, 1);

        // RAW on X2, released by same-cycle writeback on the third cycle
        drive(1, 2, 0, 0, 0, 0, 0, 0); step(); step();
        drive(1, 2, 0, 0, 0, 0, 1, 2); step();
        chk("t2_cnt", stall_cycles, 2);
        chk("t2_pending", pending, 32'h0);

        // Zero register is never tracked
        drive(1, ZR, 0, 0, 1, ZR, 0, 0); repeat (3) step();
        chk("t3_pending", pending, 32'h0);
        chk("t3_inflight", inflight, 0);

        // Fill to MAX_INFLIGHT, fifth write stalls, then issues alongside a retire
        for (int r = 1; r <= 4; r++) begin drive(1, ZR, 0, 0, 1, r, 0, 0); step(); end
        chk("t4_inflight", inflight, 4);
        drive(1, ZR, 0, 0, 1, 5, 0, 0); step();
        chk("t4_full_pending", pending, 32'h1E);
        drive(1, ZR, 0, 0, 1, 5, 1, 1); step();
        chk("t4_swap_inflight", inflight, 4);
        chk("t4_swap_pending", pending, 32'h3C);
        // Drain; sources name pending regs but id_valid is low, so no stall
        for (int r = 2; r <= 5; r++) begin drive(0, 5, 1, 4, 0, 0, 1, r); step(); end
        chk("t4_drained", inflight, 0);

        // WAW released by same-register writeback; bit stays set
        drive(1, ZR, 0, 0, 1, 3, 0, 0); step();
        drive(1, ZR, 0, 0, 1, 3, 1, 3); step();
        chk("t5_pending", pending, 32'h8);
        chk("t5_inflight", inflight, 1);
        drive(0, ZR, 0, 0, 0, 0, 1, 3); step();
        chk("t5_cleared", pending, 32'h0);

        // Writeback of a non-pending register
        drive(1, ZR, 0, 0, 1, 6, 0, 0); step();
        drive(0, ZR, 0, 0, 0, 0, 1, 7); step();
        chk("t6_err", err, 1);
        chk("t6_pending", pending, 32'h40);
        do_reset();
        chk("t6_rst_err", err, 0);
        chk("t6_rst_pending", pending, 32'h0);
        chk("t6_rst_cnt", stall_cycles, 0);

        // Non-one-hot source select: error, issue suppressed
        drive(1, ZR, 0, 0, 1, 9, 0, 0); rn_sel = '0; step();
        chk("t7_err", err, 1);
        chk("t7_pending", pending, 32'h0);
        do_reset();

        // Stall counter saturation
        drive(1, ZR, 0, 0, 1, 1, 0, 0); step();
        drive(1, 1, 0, 0, 0, 0, 0, 0); repeat (20) step();
        chk("t8_sat", stall_cycles, (1 << CW) - 1);
        drive(0, ZR, 0, 0, 0, 0, 1, 1); step();
        do_reset();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            drive($urandom_range(0, 3) != 0, pick(), $urandom_range(0, 1) == 1, pick(),
                  $urandom_range(0, 2) != 0, pick(), 0, ZR);
            if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1;
                wb_sel   = oh(outq[$urandom_range(0, outq.size() - 1)]);
            end else if ($urandom_range(0, 59) == 0) begin
                wb_valid = 1'b1;
                wb_sel   = oh(pick());
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
